// File: rtl/rvmyth_dac_feeder_pkg.sv
// Shared encodings and default sizes for the rvmyth core -> DAC feeder.
// Latency: none (types and constants only).
// Backpressure: none.
package rvmyth_dac_pkg;

    localparam int DEF_DW    = 10;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_DIV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/rvmyth_dac_feeder_if.sv
// Control and data bundle between the core-side driver (master) and the feeder (slave).
// Latency: none (wiring only).
// Backpressure: none; the feeder drops words on overflow and reports it.
interface rvmyth_dac_feeder_if
    import rvmyth_dac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV_W = DEF_DIV_W
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             en;
    logic [DIV_W-1:0] div;
    logic [DW-1:0]    in_data;
    logic             clr_flags;
    logic [DW-1:0]    dac_d;
    logic             dac_strobe;
    logic [LW-1:0]    fifo_level;
    logic             overflow;
    logic             underrun;

    modport master (
        output en, div, in_data, clr_flags,
        input  dac_d, dac_strobe, fifo_level, overflow, underrun
    );

    modport slave (
        input  en, div, in_data, clr_flags,
        output dac_d, dac_strobe, fifo_level, overflow, underrun
    );

endinterface

// File: rtl/rvmyth_dac_feeder_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
// Latency: a pushed word is readable on rdata the cycle after the push edge (no bypass).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module dac_sync_fifo
    import rvmyth_dac_pkg::*;
#(
    parameter int  DW    = DEF_DW,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [LW-1:0] r_wptr;
    logic [LW-1:0] r_rptr;
    logic          w_wr;
    logic          w_rd;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;
    assign rdata = r_mem[r_rptr[AW-1:0]];

    // A pop frees the slot the write needs, so a full FIFO can push and pop together.
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + LW'(1);
            if (w_rd) r_rptr <= r_rptr + LW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rvmyth_dac_feeder.sv
// Retimes irregular core OUT changes onto a fixed DAC sample tick; sticky flags under RVMYTH_DAC_FEEDER_FLAGS_EN.
// Latency: change before edge N is queued at N; earliest dac_d update at N+1, strobe the cycle after the tick.
// Backpressure: none upstream; words are dropped when full, DAC word held when empty.
module rvmyth_dac_feeder
    import rvmyth_dac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic CLK,
    input  logic reset_n,
    rvmyth_dac_feeder_if.slave bus
);
    localparam int            LW   = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_last;
    logic [DW-1:0]    r_dac_d;
    logic             r_strobe;
    logic [DIV_W-1:0] r_cnt;
    logic [DW-1:0]    w_rdata;
    logic [LW-1:0]    w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_tick;
    logic             w_pop;
    logic             w_starve;

    assign w_push = bus.en && (bus.in_data != r_last);
    // ">=" rather than "==" so lowering div below cnt wraps on the next edge.
    assign w_tick = (r_state != ST_IDLE) && (r_cnt >= bus.div);

    dac_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .flush   (!bus.en),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (bus.in_data),
        .rdata   (w_rdata),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_starve    = 1'b0;
        if (!bus.en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_PRIME;
                ST_PRIME: if (w_level >= HALF) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_tick) begin
                        w_pop    = !w_empty;
                        w_starve = w_empty;
                        if (w_empty) w_state_nxt = ST_PRIME;
                    end
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last   <= '0;
            r_dac_d  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= w_pop;
            if (w_push) r_last  <= bus.in_data;
            if (w_pop)  r_dac_d <= w_rdata;
            if (!bus.en || r_state == ST_IDLE || w_tick) r_cnt <= '0;
            else                                         r_cnt <= r_cnt + DIV_W'(1);
        end
    end

`ifdef RVMYTH_DAC_FEEDER_FLAGS_EN
    logic r_ovf;
    logic r_udr;
    logic w_ovf_set;

    assign w_ovf_set = w_push && w_full && !w_pop;

    // Set beats clear when both land on the same edge.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udr <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_flags);
            r_udr <= w_starve  | (r_udr & ~bus.clr_flags);
        end
    end

    assign bus.overflow = r_ovf;
    assign bus.underrun = r_udr;
`else
    logic w_unused;
    assign w_unused     = ^{bus.clr_flags, w_full};
    assign bus.overflow = 1'b0;
    assign bus.underrun = 1'b0;
`endif

    assign bus.dac_d      = r_dac_d;
    assign bus.dac_strobe = r_strobe;
    assign bus.fifo_level = w_level;

endmodule

// File: tb/tb_rvmyth_dac_feeder.sv
// Directed bench for rvmyth_dac_feeder: scoreboard of queued words checked at each strobe.
// Flag expectations follow RVMYTH_DAC_FEEDER_FLAGS_EN.
module tb_rvmyth_dac_feeder;
    import rvmyth_dac_pkg::*;

`ifdef RVMYTH_DAC_FEEDER_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rvmyth_dac_feeder_if #(.DW(10), .DEPTH(8), .DIV_W(8)) bus ();

    rvmyth_dac_feeder #(.DW(10), .DEPTH(8), .DIV_W(8)) dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int          n_chk    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_strobe = 0;
    int          prev_cyc = 0;
    int          gap_exp  = 0;
    bit          chk_gap  = 1'b0;
    bit          have_prev = 1'b0;
    logic [31:0] mon_exp;
    logic [9:0]  sbq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_strobe < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(n_strobe), 32'(target));
    endtask

    always @(posedge clk) cyc++;

    // 0xFFFFFFFF marks "no word was queued", which a 10-bit dac_d can never match.
    always @(posedge clk) begin
        #1;
        if (bus.dac_strobe === 1'b1) begin
            n_strobe++;
            mon_exp = (sbq.size() > 0) ? 32'(sbq.pop_front()) : 32'hFFFF_FFFF;
            check("strobe_dac_d", 32'(bus.dac_d), mon_exp);
            if (chk_gap && have_prev) check("strobe_gap", 32'(cyc - prev_cyc), 32'(gap_exp));
            prev_cyc  = cyc;
            have_prev = 1'b1;
        end
    end

    initial begin
        int base;
        rst_n         = 1'b1;
        bus.en        = 1'b0;
        bus.div       = '0;
        bus.in_data   = '0;
        bus.clr_flags = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_dac_d",    32'(bus.dac_d),      32'(0));
        check("rst_strobe",   32'(bus.dac_strobe), 32'(0));
        check("rst_level",    32'(bus.fifo_level), 32'(0));
        check("rst_overflow", 32'(bus.overflow),   32'(0));
        check("rst_underrun", 32'(bus.underrun),   32'(0));
        check("rst_state",    32'(dut.r_state),    32'(ST_IDLE));
        @(negedge clk) rst_n = 1'b1;

        // Idle: en low, in_data toggling, nothing may move
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 10'(i * 37 + 1);
            @(negedge clk);
        end
        check("idle_dac_d",   32'(bus.dac_d),      32'(0));
        check("idle_level",   32'(bus.fifo_level), 32'(0));
        check("idle_strobes", 32'(n_strobe),       32'(0));

        // Prime and replay at div=3
        gap_exp   = 4;
        have_prev = 1'b0;
        chk_gap   = 1'b1;
        bus.en    = 1'b1;
        bus.div   = 8'd3;
        for (int v = 1; v <= 5; v++) begin
            if (v == 5) begin
                check("prime_level", 32'(bus.fifo_level), 32'(4));
                check("prime_state", 32'(dut.r_state),    32'(ST_PRIME));
            end
            bus.in_data = 10'(v);
            sbq.push_back(10'(v));
            @(negedge clk);
        end
        check("run_state", 32'(dut.r_state),    32'(ST_RUN));
        check("run_level", 32'(bus.fifo_level), 32'(5));
        wait_strobes(5, 60, "replay_count");

        // Underrun: next tick finds the FIFO empty
        repeat (4) @(negedge clk);
        chk_gap = 1'b0;
        check("udr_flag",   32'(bus.underrun),   32'(FLAGS_ON));
        check("udr_dac_d",  32'(bus.dac_d),      32'(5));
        check("udr_strobe", 32'(bus.dac_strobe), 32'(0));
        check("udr_state",  32'(dut.r_state),    32'(ST_PRIME));
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        check("udr_cleared", 32'(bus.underrun), 32'(0));

        // Overflow: div=255, ten distinct pushes, only the first eight survive
        bus.en = 1'b0;
        @(negedge clk);
        bus.en  = 1'b1;
        bus.div = 8'd255;
        for (int v = 0; v < 10; v++) begin
            if (v == 8) begin
                check("ovf_level_full", 32'(bus.fifo_level), 32'(8));
                check("ovf_not_yet",    32'(bus.overflow),   32'(0));
            end
            bus.in_data = 10'(16 + v);
            if (v < 8) sbq.push_back(10'(16 + v));
            @(negedge clk);
        end
        check("ovf_level_sat", 32'(bus.fifo_level), 32'(8));
        check("ovf_flag",      32'(bus.overflow),   32'(FLAGS_ON));
        base = n_strobe;
        wait_strobes(base + 8, 2400, "ovf_replay_count");
        check("ovf_sb_drained", 32'(sbq.size()), 32'(0));

        // Back to IDLE with a flag clear
        bus.en        = 1'b0;
        bus.clr_flags = 1'b1;
        @(negedge clk);
        bus.clr_flags = 1'b0;
        check("idle_flush_level", 32'(bus.fifo_level), 32'(0));
        check("idle_ovf_clear",   32'(bus.overflow),   32'(0));
        check("idle_state",       32'(dut.r_state),    32'(ST_IDLE));

        // Boundary: full FIFO, push and tick on the same edge with div=0
        bus.en  = 1'b1;
        bus.div = 8'd255;
        for (int v = 0; v < 8; v++) begin
            bus.in_data = 10'(32 + v);
            sbq.push_back(10'(32 + v));
            @(negedge clk);
        end
        check("bnd_full", 32'(bus.fifo_level), 32'(8));
        gap_exp   = 1;
        have_prev = 1'b0;
        chk_gap   = 1'b1;
        base      = n_strobe;
        bus.in_data = 10'(40);
        bus.div     = 8'd0;
        sbq.push_back(10'(40));
        @(negedge clk);
        check("bnd_level",    32'(bus.fifo_level), 32'(8));
        check("bnd_overflow", 32'(bus.overflow),   32'(0));
        check("bnd_dac_d",    32'(bus.dac_d),      32'(32));
        check("bnd_strobe",   32'(bus.dac_strobe), 32'(1));
        wait_strobes(base + 9, 30, "bnd_drain_count");
        chk_gap = 1'b0;

        // Async reset mid-RUN, between clock edges
        bus.en = 1'b0;
        @(negedge clk);
        bus.en  = 1'b1;
        bus.div = 8'd3;
        for (int v = 0; v < 5; v++) begin
            bus.in_data = 10'(48 + v);
            sbq.push_back(10'(48 + v));
            @(negedge clk);
        end
        base = n_strobe;
        wait_strobes(base + 1, 20, "arst_first_strobe");
        #2 rst_n = 1'b0;
        #1;
        check("arst_dac_d",    32'(bus.dac_d),      32'(0));
        check("arst_strobe",   32'(bus.dac_strobe), 32'(0));
        check("arst_level",    32'(bus.fifo_level), 32'(0));
        check("arst_overflow", 32'(bus.overflow),   32'(0));
        check("arst_underrun", 32'(bus.underrun),   32'(0));
        check("arst_state",    32'(dut.r_state),    32'(ST_IDLE));
        sbq.delete();
        bus.in_data = '0;
        @(negedge clk) rst_n = 1'b1;
        base = n_strobe;
        repeat (6) @(negedge clk);
        check("post_rst_level",   32'(bus.fifo_level), 32'(0));
        check("post_rst_strobes", 32'(n_strobe),       32'(base));
        check("post_rst_dac_d",   32'(bus.dac_d),      32'(0));
        check("post_rst_state",   32'(dut.r_state),    32'(ST_PRIME));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rvmyth_dac_feeder.md
# rvmyth_dac_feeder

Downstream stage between the rvmyth core's 10-bit `OUT` bus and the 10-bit DAC inside vsdminisoc, clocked by the same PLL-derived `CLK`. The core changes `OUT` at irregular instruction-driven times, and the DAC must be updated at a fixed, programmable sample rate. This block does three things:
- detects each new core value;
- buffers new values in a small FIFO;
- replays them to the DAC, one word per sample tick, with a priming phase and underrun/overflow reporting.

## Interface
Parameters:
- `DW`, 10: sample width (matches core `OUT`).
- `DEPTH`, 8: FIFO depth. Must be a power of 2, ≥ 4.
- `DIV_W`, 8: width of the sample-period divider.

Ports:
- `CLK` input 1: PLL output clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: enable. Low means IDLE: the FIFO is flushed and `dac_d` is held.
- `div` input DIV_W: sample period minus 1. One tick occurs every `div+1` cycles.
- `in_data` input DW: core `OUT` bus.
- `clr_flags` input 1: one-cycle pulse that clears the sticky flags.
- `dac_d` output DW: registered DAC word.
- `dac_strobe` output 1: one-cycle pulse when `dac_d` takes a new value.
- `fifo_level` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; a sample was dropped because the FIFO was full.
- `underrun` output 1: sticky; a tick occurred in RUN with the FIFO empty.

## Operation
Change detection:
- Register `last` holds the most recently accepted `in_data`.
- A push occurs on any edge where `en=1` and `in_data != last`. That edge loads `last`.
- `last` resets to 0.

FIFO rules:
- Push when full: the write is dropped, `last` is still updated, and `overflow` is set.
- Push and pop in the same cycle when full: both succeed and the level is unchanged.
- Push and pop in the same cycle when empty: there is no bypass. The pop sees empty and the push lands.

Prescaler:
- Counter `cnt` runs 0..`div`. The tick occurs at `cnt==div`, then `cnt` returns to 0.
- `div=0` gives a tick every cycle.
- If `div` is written below the current `cnt`, a tick occurs on the next cycle and the counter wraps.
- `cnt` is held at 0 while in IDLE.

FSM (states IDLE, PRIME, RUN):
- IDLE → PRIME when `en=1`.
- PRIME → RUN when `fifo_level ≥ DEPTH/2`. The transition is evaluated every cycle. No pops occur in PRIME.
- RUN, on a tick with the FIFO non-empty: pop, load the word into `dac_d`, and pulse `dac_strobe`.
- RUN, on a tick with the FIFO empty: set `underrun`, go to PRIME, and hold `dac_d`.
- Any state → IDLE when `en=0`. On entering IDLE: flush the FIFO (level 0), hold `dac_d`, and keep the flags.

Sticky flags:
- `clr_flags` clears both flags.
- If `clr_flags` and a set event occur in the same cycle, set wins.

## Timing
Reset values:
- `dac_d=0`, `dac_strobe=0`, `fifo_level=0`, `overflow=0`, `underrun=0`.
- State is IDLE, `cnt=0`, `last=0`.

Latency:
- `in_data` changes before edge N → `fifo_level` increments after edge N.
- The earliest that word can appear on `dac_d` is after edge N+1 (RUN, level was ≥1, tick at N+1).
- `dac_strobe` is high for exactly the cycle after the tick edge.

Back-to-back operation:
- Consecutive changes can push on every cycle.
- With `div=0`, one pop per cycle is sustained.

Mid-operation changes:
- `reset_n` asserted mid-operation forces all reset values immediately, with no clock needed.
- `en` deasserted mid-stream takes effect at the next edge. A tick coinciding with that edge does not pop.

## Configuration
Macro `RVMYTH_DAC_FEEDER_FLAGS_EN`:
- Defined: `overflow` and `underrun` sticky logic and `clr_flags` are implemented as above.
- Undefined: `overflow` and `underrun` are tied to 0, and `clr_flags` is ignored.
- All other behaviour is identical in both builds, including drop-on-full and RUN→PRIME on underrun.

## Structure
Shared include/package `rvmyth_dac_pkg`:
- State encodings `ST_IDLE=2'd0`, `ST_PRIME=2'd1`, `ST_RUN=2'd2`.
- Default `DW`/`DEPTH` constants.

One sub-module, `dac_sync_fifo`:
- Single-clock FIFO parameterized by DW and DEPTH.
- Pointers one bit wider than the address, with full/empty derived from them.
- Ports: push, pop, wdata, rdata, level, full, empty, flush.

The top level holds change detection, the prescaler, the FSM and the flags.

## Test plan
- Reset/idle: after `reset_n` is released with `en=0` and `in_data` toggling, `dac_d=0`, `dac_strobe` never pulses, `fifo_level=0`.
- Prime and replay: with `en=1`, `div=3`, `in_data` = 1, 2, 3, 4, 5 on consecutive cycles, RUN is entered once the level reaches 4. After that, `dac_d` = 1, 2, 3, 4, 5 with strobes exactly 4 cycles apart.
- Underrun: in RUN, stop `in_data` changes and drain the FIFO. The next tick sets `underrun=1`, `dac_d` stays 5, the state returns to PRIME, and `clr_flags` then clears the flag.
- Overflow: `div=255`, 10 distinct pushes, no pops. `fifo_level` saturates at 8, `overflow=1`, and replay yields only the first 8 values.
- Boundary: `div=0`, full FIFO, a push and a tick in the same cycle. The level stays at 8, there is no overflow, and the oldest word appears on `dac_d`.
- Async reset mid-RUN: pulse `reset_n` low between edges. All outputs go to 0 immediately. Set `in_data=0` so that `in_data == last` after reset; no push occurs.
